// File: rtl/sim_result_uart_tx.sv
// sim_result_uart_tx: captures one result snapshot and streams it as a 13-byte 8N1 UART frame
module sim_result_uart_tx #(
  parameter int CLKS_PER_BIT = 1250,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        capture,
  input  logic        flag,
  input  logic [15:0] word_a,
  input  logic [31:0] word_b,
  input  logic [15:0] word_c,
  input  logic [15:0] word_d,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        overrun
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  state_t state;
  logic [79:0] words, shadow;
  logic flag_q;
  logic [7:0] csum, cs_in, shift, nxt;
  logic [3:0] idx;
  logic [2:0] bits;
  logic [CW-1:0] cnt;
  logic accept;
  assign words = {word_a, word_b, word_c, word_d};
  assign accept = capture && (state == IDLE || state == DONE);
  always_comb begin
    cs_in = {7'b0, flag};
    for (int i = 0; i < 10; i++) cs_in = cs_in ^ words[8*i +: 8];
  end
  // nxt is the byte following idx; shadow bytes occupy frame positions 2..11
  always_comb nxt = idx == 4'd0  ? {7'b0, flag_q} :
                    idx == 4'd11 ? csum :
                    8'(shadow >> (8 * (10 - int'(idx))));
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
      shadow  <= '0;
      flag_q  <= 1'b0;
      csum    <= '0;
      shift   <= '0;
      idx     <= '0;
      bits    <= '0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      if (capture && busy) overrun <= 1'b1;
      if (accept) begin
        shadow <= words;
        flag_q <= flag;
        csum   <= cs_in;
        shift  <= SYNC_BYTE;
        idx    <= '0;
        bits   <= '0;
        cnt    <= '0;
        tx     <= 1'b0;
        busy   <= 1'b1;
        state  <= START;
      end else if (state == DONE) begin
        state <= IDLE;
      end else if (state != IDLE) begin
        cnt <= cnt == LAST ? '0 : cnt + CW'(1);
        if (cnt == LAST) begin
          case (state)
            START: begin
              state <= DATA;
              tx    <= shift[0];
            end
            DATA: begin
              bits  <= bits + 3'd1;
              shift <= shift >> 1;
              state <= bits == 3'd7 ? STOP : DATA;
              tx    <= bits == 3'd7 ? 1'b1 : shift[1];
            end
            STOP: begin
              if (idx == 4'd12) begin
                state <= DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                idx   <= idx + 4'd1;
                shift <= nxt;
                tx    <= 1'b0;
                state <= START;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_sim_result_uart_tx.sv
// tb_sim_result_uart_tx: directed and random frames checked against a byte-level UART line model
module tb_sim_result_uart_tx;
  localparam int CPB = 4;
  localparam int FL = 13 * 10 * CPB;
  logic clock = 1'b0, reset = 1'b1, capture = 1'b0, flag = 1'b0;
  logic [15:0] word_a = '0, word_c = '0, word_d = '0;
  logic [31:0] word_b = '0;
  logic tx, busy, done, overrun;
  int total = 0, bad = 0;

  always #5 clock = ~clock;

  sim_result_uart_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clock(clock), .reset(reset), .capture(capture), .flag(flag),
    .word_a(word_a), .word_b(word_b), .word_c(word_c), .word_d(word_d),
    .tx(tx), .busy(busy), .done(done), .overrun(overrun)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Frame contents straight from the byte list: sync, flag, words MSB first, XOR of bytes 1..11
  function automatic void model(input logic f, input logic [15:0] a, input logic [31:0] b,
                                input logic [15:0] c, input logic [15:0] d, output logic [7:0] q[13]);
    logic [7:0] src[10];
    src = '{a[15:8], a[7:0], b[31:24], b[23:16], b[15:8], b[7:0], c[15:8], c[7:0], d[15:8], d[7:0]};
    q[0] = 8'hA5;
    q[1] = {7'b0, f};
    for (int i = 0; i < 10; i++) q[2+i] = src[i];
    q[12] = 8'h00;
    for (int i = 1; i < 12; i++) q[12] = q[12] ^ q[i];
  endfunction

  // mode 0: single-cycle capture; 1: inputs zeroed after capture; 2: extra capture mid-frame; 3: capture held
  task automatic frame(input logic f, input logic [15:0] a, input logic [31:0] b,
                       input logic [15:0] c, input logic [15:0] d, input int mode, input string tag);
    logic [7:0] q[13];
    logic ln[FL];
    logic [39:0] e, o;
    int nb, nd;
    model(f, a, b, c, d, q);
    flag = f; word_a = a; word_b = b; word_c = c; word_d = d;
    capture = 1'b1;
    tick;
    if (mode != 3) capture = 1'b0;
    if (mode == 1) begin
      flag = 1'b0; word_a = '0; word_b = '0; word_c = '0; word_d = '0;
    end
    nb = 0;
    nd = 0;
    for (int i = 0; i < FL; i++) begin
      ln[i] = tx;
      nb += int'(busy);
      nd += int'(done);
      if (mode == 2) capture = (i == 99);
      tick;
    end
    chk({tag, " busy_cycles"}, 64'(nb), 64'(FL));
    chk({tag, " done_in_frame"}, 64'(nd), 64'd0);
    chk({tag, " done_cycle"}, {61'b0, tx, busy, done}, 64'b101);
    for (int bi = 0; bi < 13; bi++) begin
      for (int k = 0; k < 10; k++)
        for (int j = 0; j < CPB; j++) begin
          e[k*CPB+j] = k == 0 ? 1'b0 : k == 9 ? 1'b1 : q[bi][k-1];
          o[k*CPB+j] = ln[bi*10*CPB + k*CPB + j];
        end
      chk($sformatf("%s byte%0d", tag, bi), 64'(o), 64'(e));
    end
    if (mode != 3) begin
      tick;
      chk({tag, " after_done"}, {61'b0, tx, busy, done}, 64'b100);
    end
  endtask

  initial begin
    int nd, nt;
    repeat (3) tick;
    reset = 1'b0;
    chk("reset_state", {60'b0, tx, busy, done, overrun}, 64'b1000);
    nt = 0;
    for (int i = 0; i < 100; i++) begin
      nt += int'({tx, busy, done, overrun} != 4'b1000);
      tick;
    end
    chk("idle_100", 64'(nt), 64'd0);

    frame(1'b1, 16'h1234, 32'hDEADBEEF, 16'h0001, 16'hFFFF, 0, "directed");
    chk("directed overrun", 64'(overrun), 64'd0);
    frame(1'b1, 16'h1234, 32'hDEADBEEF, 16'h0001, 16'hFFFF, 1, "inputs_zeroed");
    for (int r = 0; r < 3; r++)
      frame(1'($urandom), 16'($urandom), $urandom, 16'($urandom), 16'($urandom), 0,
            $sformatf("random%0d", r));
    chk("pre_overrun", 64'(overrun), 64'd0);

    frame(1'b0, 16'hA5A5, 32'h0F0F00FF, 16'h8000, 16'h0000, 2, "overrun_frame");
    chk("overrun_set", 64'(overrun), 64'd1);
    nt = 0;
    for (int i = 0; i < 50; i++) begin
      nt += int'(busy) + int'(!tx);
      tick;
    end
    chk("no_frame_without_capture", 64'(nt), 64'd0);
    frame(1'($urandom), 16'($urandom), $urandom, 16'($urandom), 16'($urandom), 0, "after_overrun");
    chk("overrun_sticky", 64'(overrun), 64'd1);

    for (int r = 0; r < 3; r++)
      frame(1'($urandom), 16'($urandom), $urandom, 16'($urandom), 16'($urandom), 3,
            $sformatf("held%0d", r));
    capture = 1'b0;
    tick;
    chk("held_end", {61'b0, tx, busy, done}, 64'b100);

    flag = 1'b1; word_a = 16'($urandom); word_b = $urandom; word_c = 16'($urandom); word_d = 16'($urandom);
    capture = 1'b1;
    tick;
    capture = 1'b0;
    repeat (215) tick;
    chk("mid_byte5_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    tick;
    chk("mid_reset", {60'b0, tx, busy, done, overrun}, 64'b1000);
    reset = 1'b0;
    nd = 0;
    nt = 0;
    for (int i = 0; i < 600; i++) begin
      nd += int'(done);
      nt += int'(!tx) + int'(busy);
      tick;
    end
    chk("no_done_after_abort", 64'(nd), 64'd0);
    chk("line_idle_after_abort", 64'(nt), 64'd0);
    frame(1'($urandom), 16'($urandom), $urandom, 16'($urandom), 16'($urandom), 0, "post_reset");
    chk("post_reset_overrun", 64'(overrun), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sim_result_uart_tx.md
# sim_result_uart_tx

Serialises one snapshot of the circuit-simulator result outputs (a 1-bit flag plus 16/32/16/16-bit result words) into a fixed 13-byte UART frame for the host PC. It sits directly downstream of the simulated circuit block on the Elbert board. It captures the result values on request, then streams them out on a single 8N1 TX line with a sync byte and XOR checksum.

## Interface
- CLKS_PER_BIT, default 1250, clock cycles per UART bit (12 MHz / 9600 baud); legal range ≥ 2
- SYNC_BYTE, default 8'hA5, first byte of every frame

- clock  in  1  system clock, rising-edge
- reset  in  1  synchronous, active-high
- capture  in  1  request: latch inputs and send a frame
- flag  in  1  1-bit result
- word_a  in  16  result word A
- word_b  in  32  result word B
- word_c  in  16  result word C
- word_d  in  16  result word D
- tx  out  1  UART line, idle high
- busy  out  1  high while a frame is in flight
- done  out  1  one-cycle pulse when a frame completes
- overrun  out  1  sticky: capture arrived while busy

## Operation
- Frame order, bytes 0..12: SYNC_BYTE, {7'b0, flag}, word_a[15:8], word_a[7:0], word_b[31:24]..word_b[7:0] (4 bytes), word_c MSB then LSB, word_d MSB then LSB, checksum.
- Checksum = XOR of bytes 1..11. SYNC is excluded.
- Each byte is sent as a start bit (0), then data bits LSB first, then a stop bit (1).
- Inputs are latched into an 80-bit shadow register on the accepting edge. Input changes after acceptance do not affect the frame in flight.
- FSM states:
  - IDLE: tx=1. On capture=1, latch inputs, clear byte index → START.
  - START: tx=0 for CLKS_PER_BIT cycles → DATA.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, 8 bits → STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If byte index = 12 → DONE; else increment index, load next byte → START.
  - DONE: one cycle, done=1, busy=0 → IDLE.
- Bit-period counter and bit counter are width-sized from CLKS_PER_BIT and reset to 0 on every bit boundary.
- Capture while busy=1 is ignored and sets overrun=1. overrun clears only on reset.
- Capture in the DONE cycle is accepted, giving back-to-back frames.

## Timing
- Reset values: tx=1, busy=0, done=0, overrun=0. FSM is in IDLE and the shadow register is 0.
- Reset mid-frame: the next edge forces tx=1 and busy=0 and aborts the frame. No done pulse.
- Capture sampled high at edge N gives busy=1 and tx=0 from edge N (registered outputs), i.e. visible in cycle N+1.
- Frame length: exactly 13×10×CLKS_PER_BIT cycles of tx activity.
- After the final stop bit: done=1 for exactly 1 cycle and busy=0 in that same cycle.
- Back-to-back frames: a capture accepted in the DONE cycle makes the next start bit begin 1 cycle after the previous stop bit ends.
- All outputs are registered. No combinational path from inputs to tx.

## Test plan
- Reset then idle 100 cycles → tx=1, busy=0, done=0, overrun=0 throughout.
- CLKS_PER_BIT=4. Capture 1 cycle with flag=1, word_a=16'h1234, word_b=32'hDEADBEEF, word_c=16'h0001, word_d=16'hFFFF. Required:
  - decoded bytes A5 01 12 34 DE AD BE EF 00 01 FF FF 04;
  - each bit exactly 4 cycles;
  - busy high for 520 cycles, then a single done pulse.
- Same frame, inputs changed to 0 one cycle after capture → transmitted bytes unchanged.
- Capture pulsed again at cycle 100 of a frame → frame unaffected and overrun=1. A second frame starts only on a later capture. overrun stays 1 until reset.
- Capture held high continuously for 3 frames → three contiguous frames with a 1-cycle idle gap at each DONE, and 3 done pulses.
- Reset asserted during byte 5 → tx=1 and busy=0 on the next edge, no done pulse. A fresh capture then produces a complete correct frame starting with A5.
